srff_bank: RTL
==============

# srff_bank

Parametrised multi-mode flip-flop bank: WIDTH independent storage bits sharing one clock, asynchronous active-low reset, clock enable and a runtime-selectable update mode (SR, JK, D, T). SR mode has a configurable resolution for the S=R=1 condition. The bank also tracks those illegal SR inputs with a sticky flag and a saturating event counter. It is the general-purpose successor to the single-bit SR flip-flop and serves as the state-holding primitive for control and status registers.

## Interface
- WIDTH, 8, number of storage bits (≥1)
- SET_PRIORITY, 1, SR-mode resolution of S=R=1: 1 → bit sets, 0 → bit resets
- CNT_W, 8, width of illegal-event counter (≥1)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  clock enable; 0 → all bits hold
- mode  input  2  00 SR, 01 JK, 10 D, 11 T; global to all bits
- s  input  WIDTH  S / J / D / T input per bit, by mode
- r  input  WIDTH  R / K input per bit; ignored in D and T modes
- clr_err  input  1  synchronous clear of illegal and illegal_cnt
- q  output  WIDTH  stored state
- qbar  output  WIDTH  complement of q
- chg  output  WIDTH  bits that changed value on the last edge
- illegal  output  1  sticky: an SR-mode S=R=1 has occurred since reset or clear
- illegal_cnt  output  CNT_W  saturating count of cycles with an illegal event

## Operation
- Reset (rst_n=0, asynchronous, no clock needed): q=0, qbar=all ones, chg=0, illegal=0, illegal_cnt=0.
- en=0: q and qbar hold; chg=0 after the edge; no illegal event is counted. clr_err still acts.
- With en=1, each bit i updates on the edge as follows:
  - SR mode: s=1,r=0 → 1; s=0,r=1 → 0; s=0,r=0 → hold; s=1,r=1 → SET_PRIORITY ? 1 : 0.
  - JK mode: same as SR, except s=1,r=1 → toggle.
  - D mode: q ← s.
  - T mode: q ← q ^ s.
- Illegal event: en=1 and mode=SR and |(s & r).
  - Counted once per cycle, regardless of how many bits are illegal.
  - Sets illegal.
  - Increments illegal_cnt, saturating at 2^CNT_W−1 with no wrap.
  - JK, D and T modes never raise illegal events.
- clr_err=1 with no event on the same edge: illegal=0, illegal_cnt=0.
- clr_err=1 with an event on the same edge: the event wins over the clear, giving illegal=1, illegal_cnt=1.
- chg = q_next ^ q_current, registered when en=1; 0 when en=0.
- qbar = ~q at all times, including reset; q and qbar are never equal.
- mode may change on any cycle; the new mode applies at that edge, with no pipeline and no settling cycle.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Latency is 1 cycle: inputs sampled at edge N appear on q, qbar, chg, illegal and illegal_cnt after edge N.
- Reset assertion acts immediately. Release is synchronous-safe; the first update occurs on the first rising edge with rst_n=1.
- Reset mid-operation discards all state, including the counter and the sticky flag.
- Throughput is one update per cycle per bit.

## Structure
- Shared package srff_pkg holds:
  - mode constants MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11
  - a mode typedef
- Sub-module srff_cell: one-bit next-state logic plus storage flop, with ports clk, rst_n, en, mode, s, r, set_pri, q, qbar, chg, illegal_bit. It is instantiated WIDTH times via generate.
- The top level ORs illegal_bit across the bank and holds the sticky flag, the saturating counter and the clr_err logic.

## Test plan
All scenarios use WIDTH=8, CNT_W=4 unless stated.
- Reset: drive rst_n=0 mid-cycle with q=8'hA5 → q=00, qbar=FF, chg=00, illegal=0, illegal_cnt=0 immediately, without a clock edge.
- SR with SET_PRIORITY=1:
  - from q=00, s=8'h0F, r=8'hF0 → q=0F, chg=0F.
  - then s=8'h03, r=8'h03 → q=0F, illegal=1, illegal_cnt=1.
  - repeat with SET_PRIORITY=0 → q=0C.
- JK and T:
  - from q=0F, mode=JK, s=FF, r=FF → q=F0, chg=FF, illegal unchanged.
  - mode=T, s=81 → q=71.
- Enable and D: q=71, en=0, mode=D, s=3C for 3 cycles → q=71, chg=00; en=1 → q=3C after one edge, chg=4D.
- Counter saturation: 20 consecutive illegal SR cycles → illegal_cnt stops at 15.
  - clr_err alone → illegal=0, illegal_cnt=0.
  - clr_err together with an illegal event → illegal=1, illegal_cnt=1.
- Mode switch: alternate mode SR/D every cycle with random s and r for 1000 cycles → q matches the reference model each cycle, and qbar==~q always.

Source files
------------

// File: rtl/srff_pkg.sv
// srff_pkg: shared mode encoding for the srff_bank flip-flop bank.
package srff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    // Illegal SR input: both S and R asserted on any bit while in SR mode.
    function automatic logic is_sr_clash(
        input mode_t m,
        input logic  s,
        input logic  r
    );
        return (m == MODE_SR) && s && r;
    endfunction

endpackage

// File: rtl/srff_bank_if.sv
// srff_bank_if: control inputs and state/status outputs of the bank.
interface srff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import srff_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] chg;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output en, mode, s, r, clr_err,
        input  q, qbar, chg, illegal, illegal_cnt
    );

    modport slave (
        input  en, mode, s, r, clr_err,
        output q, qbar, chg, illegal, illegal_cnt
    );

endinterface

// File: rtl/srff_cell.sv
// srff_cell: one storage bit with SR/JK/D/T next-state logic.
module srff_cell
    import srff_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  mode_t mode,
    input  logic  s,
    input  logic  r,
    input  logic  set_pri,
    output logic  q,
    output logic  qbar,
    output logic  chg,
    output logic  illegal_bit
);

    logic q_r;
    logic chg_r;
    logic q_nxt;

    always_comb begin
        q_nxt = q_r;
        unique case (mode)
            MODE_SR: begin
                unique case ({s, r})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = set_pri;
                    default: q_nxt = q_r;
                endcase
            end
            MODE_JK: begin
                unique case ({s, r})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = ~q_r;
                    default: q_nxt = q_r;
                endcase
            end
            MODE_D:  q_nxt = s;
            MODE_T:  q_nxt = q_r ^ s;
            default: q_nxt = q_r;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= 1'b0;
            chg_r <= 1'b0;
        end else if (en) begin
            q_r   <= q_nxt;
            chg_r <= q_nxt ^ q_r;
        end else begin
            chg_r <= 1'b0;
        end
    end

    // qbar comes straight off the flop so it can never disagree with q.
    assign q           = q_r;
    assign qbar        = ~q_r;
    assign chg         = chg_r;
    assign illegal_bit = en && is_sr_clash(mode, s, r);

endmodule

// File: rtl/srff_bank.sv
// srff_bank: WIDTH multi-mode flip-flops plus sticky/counted
// tracking of illegal SR inputs.
module srff_bank
    import srff_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SET_PRIORITY = 1,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    srff_bank_if.slave  bus
);

    localparam logic             SET_PRI = (SET_PRIORITY != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_v;
    logic [WIDTH-1:0] qbar_v;
    logic [WIDTH-1:0] chg_v;
    logic [WIDTH-1:0] ill_v;
    logic             ill_any;
    logic             ill_r;
    logic [CNT_W-1:0] cnt_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        srff_cell u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (bus.en),
            .mode        (bus.mode),
            .s           (bus.s[i]),
            .r           (bus.r[i]),
            .set_pri     (SET_PRI),
            .q           (q_v[i]),
            .qbar        (qbar_v[i]),
            .chg         (chg_v[i]),
            .illegal_bit (ill_v[i])
        );
    end

    assign ill_any = |ill_v;

    // An event on the same edge as clr_err wins and restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_r <= 1'b0;
            cnt_r <= '0;
        end else if (ill_any) begin
            ill_r <= 1'b1;
            if (bus.clr_err) begin
                cnt_r <= CNT_ONE;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (bus.clr_err) begin
            ill_r <= 1'b0;
            cnt_r <= '0;
        end
    end

    assign bus.q           = q_v;
    assign bus.qbar        = qbar_v;
    assign bus.chg         = chg_v;
    assign bus.illegal     = ill_r;
    assign bus.illegal_cnt = cnt_r;

endmodule
